// File: rtl/mips_shift_pkg.sv
// mips_shift_pkg: shared op and state encodings for the sequential shifter.
package mips_shift_pkg;
    typedef enum logic [1:0] {
        OP_SRL  = 2'b00,
        OP_SRA  = 2'b01,
        OP_ROTR = 2'b10,
        OP_SLL  = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;
endpackage

// File: rtl/shift_right_seq.sv
// shift_right_seq: one-bit-per-cycle shifter (SRL/SRA/ROTR/SLL) with a done pulse.
module shift_right_seq
    import mips_shift_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] data_in,
    input  logic [4:0]        shamt,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [DATA_W-1:0]   work_q, work_d, result_q, result_d, step;
    logic [4:0]          cnt_q, cnt_d;
    logic                fill;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_SRL;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = start ? (shamt == 5'd0 ? ST_DONE : ST_SHIFT) : ST_IDLE;
            ST_SHIFT: state_d = cnt_q == 5'd1 ? ST_DONE : ST_SHIFT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // SRA keeps bit 31 in place every step, so work_q[MSB] is always the original sign.
    always_comb begin
        fill = op_q == OP_SRA ? work_q[DATA_W-1] : (op_q == OP_ROTR ? work_q[0] : 1'b0);
        step = op_q == OP_SLL ? {work_q[DATA_W-2:0], 1'b0} : {fill, work_q[DATA_W-1:1]};
    end

    always_comb begin
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (state_q == ST_IDLE && start) begin
            op_d   = op_e'(op);
            work_d = data_in;
            cnt_d  = shamt;
        end
        if (state_q == ST_SHIFT) begin
            work_d = step;
            cnt_d  = cnt_q - 5'd1;
        end
        if (state_d == ST_DONE && state_q != ST_DONE)
            result_d = state_q == ST_SHIFT ? step : data_in;
    end

    always_comb begin
        busy   = state_q != ST_IDLE;
        done   = state_q == ST_DONE;
        result = result_q;
    end
endmodule

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: scoreboard bench for the sequential shifter.
module tb_shift_right_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data_in = '0, result, last_res = '0;
    logic [4:0]  shamt = '0;
    logic        busy, done;
    int          total = 0, bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    shift_right_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .data_in(data_in),
        .shamt(shamt), .busy(busy), .done(done), .result(result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        logic [63:0] rot;
        rot = {d, d} >> s;
        case (o)
            2'b00:   return d >> s;
            2'b01:   return $unsigned($signed(d) >>> s);
            2'b10:   return rot[31:0];
            default: return d << s;
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s, input bit glitch);
        int n, b, extra;
        logic [31:0] e;
        @(negedge clk);
        check("hold", result, last_res);
        check("idle_done", {31'b0, done}, 32'd0);
        start = 1'b1; op = o; data_in = d; shamt = s;
        exp_q.push_back(model(o, d, s));
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); data_in = $urandom; shamt = 5'($urandom);
        n = 1;
        b = busy ? 1 : 0;
        while (!done && n < 40) begin
            start = glitch && n == 2;
            @(negedge clk);
            n++;
            if (busy) b++;
        end
        start = 1'b0;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("done_seen", {31'b0, done}, 32'd1);
        check("latency", 32'(n), 32'(s) + 32'd1);
        check("busy_cycles", 32'(b), 32'(s) + 32'd1);
        check("result", result, e);
        last_res = e;
        if (glitch) begin
            extra = 0;
            repeat (12) begin
                @(negedge clk);
                if (done) extra++;
            end
            check("extra_done", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int extra;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;

        run_op(2'b00, 32'h8000_0000, 5'd4, 1'b0);
        run_op(2'b01, 32'h8000_0000, 5'd31, 1'b0);
        run_op(2'b10, 32'h0000_0001, 5'd1, 1'b0);
        run_op(2'b11, 32'h0000_0003, 5'd2, 1'b0);
        run_op(2'b01, 32'h1234_ABCD, 5'd0, 1'b0);
        run_op(2'b00, 32'hF000_0000, 5'd8, 1'b1);

        // abandon a long operation mid-shift; reset also wins over a simultaneous start
        @(negedge clk);
        start = 1'b1; op = 2'b00; data_in = 32'hFFFF_0000; shamt = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1; start = 1'b0;
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("midrst_nodone", 32'(extra), 32'd0);
        last_res = '0;
        run_op(2'b00, 32'hF000_0000, 5'd8, 1'b0);

        for (int i = 0; i < 20; i++)
            run_op(2'($urandom), $urandom, 5'($urandom), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
